// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave: 64-bit reads, byte-masked writes, WAIT_STATES cycles before ack/err.
// Optional WB_RAM_ALIGN_CHECK_EN: misaligned hits terminate with err_o instead of ack_o.
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module wb_ram_slave #(
  parameter logic [`DAT_WIDTH-1:0] BASE_ADR    = '0,
  parameter int                    DEPTH_WORDS = 512,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  input  logic [`DAT_WIDTH/8-1:0]   sel_i,
  input  logic [`DAT_WIDTH-1:0]     adr_i,
  input  logic [`DAT_WIDTH-1:0]     dat_i,
  output logic [`DAT_WIDTH-1:0]     dat_o,
  output logic                      ack_o,
  output logic                      err_o
);

  localparam int DW = `DAT_WIDTH;
  localparam int SW = DW / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DW-1:0] WIN_BYTES = DW'(DEPTH_WORDS) * DW'(8);
  localparam logic [3:0] WLAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem [DEPTH_WORDS];

  logic            cur_we;
  logic [SW-1:0]   cur_sel;
  logic [DW-1:0]   cur_adr;
  logic [DW-1:0]   cur_dat;
  logic [DW-1:0]   cur_off;
  logic [AW-1:0]   cur_idx;
  logic            cur_ok;
  logic            resp;
  logic            wr_en;

  // With zero wait states the response is formed straight from the bus at the capture edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we  = we_i;
      cur_sel = sel_i;
      cur_adr = adr_i;
      cur_dat = dat_i;
    end else begin
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_adr = adr_q;
      cur_dat = wdat_q;
    end
    // Offset wraps for addresses below the base, so one unsigned compare decodes the window.
    cur_off = cur_adr - BASE_ADR;
    cur_idx = cur_off[AW+2:3];
`ifdef WB_RAM_ALIGN_CHECK_EN
    cur_ok  = (cur_off < WIN_BYTES) && (cur_off[2:0] == 3'd0);
`else
    cur_ok  = (cur_off < WIN_BYTES);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    resp    = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          we_d   = we_i;
          sel_d  = sel_i;
          adr_d  = adr_i;
          wdat_d = dat_i;
          cnt_d  = 4'd0;
          if (WAIT_STATES == 0) resp = 1'b1;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WLAST) begin
          resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (resp) begin
      state_d = ST_RESP;
      cnt_d   = 4'd0;
      if (cur_ok) begin
        ack_d = 1'b1;
        if (cur_we) wr_en = 1'b1;
        else        dat_d = mem[cur_idx];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      for (int n = 0; n < SW; n++) begin
        if (cur_sel[n]) mem[cur_idx][8*n +: 8] <= cur_dat[8*n +: 8];
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (0, 1 and 3 wait states) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_wb_ram_slave;

  localparam logic [63:0] BASE  = 64'h1000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [7:0]  sel [3];
  logic [63:0] adr [3];
  logic [63:0] wdat[3];
  logic [63:0] dat_o[3];
  logic        ack_o[3];
  logic        err_o[3];

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_cnt[3] = '{0, 0, 0};
  int err_cnt[3] = '{0, 0, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_ram_slave #(
      .BASE_ADR   (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[g]), .stb_i(stb[g]), .we_i(we[g]),
      .sel_i(sel[g]), .adr_i(adr[g]), .dat_i(wdat[g]),
      .dat_o(dat_o[g]), .ack_o(ack_o[g]), .err_o(err_o[g])
    );
  end

  function automatic int ws(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  // Transaction model: a request seen at edge k answers at edge k+W unless cyc drops first;
  // the edge right after an answer never starts a new request.
  bit          m_ack[3];
  bit          m_err[3];
  bit [63:0]   m_dat[3];
  bit [63:0]   m_mem[3][DEPTH];
  bit          pend[3];
  int          resp_e[3];
  int          last_resp[3] = '{-10, -10, -10};
  bit          p_we[3];
  bit [7:0]    p_sel[3];
  bit [63:0]   p_adr[3];
  bit [63:0]   p_dat[3];
  int          edge_n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pend[i] = 1'b0; m_ack[i] = 1'b0; m_err[i] = 1'b0; m_dat[i] = '0; last_resp[i] = -10;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 3; i++) begin
        bit [63:0] off;
        bit        ok;
        int        idx;
        m_ack[i] = 1'b0;
        m_err[i] = 1'b0;
        if (!pend[i] && edge_n != last_resp[i] + 1 && cyc[i] && stb[i]) begin
          pend[i] = 1'b1; resp_e[i] = edge_n + ws(i);
          p_we[i] = we[i]; p_sel[i] = sel[i]; p_adr[i] = adr[i]; p_dat[i] = wdat[i];
        end
        if (pend[i] && !cyc[i]) begin
          pend[i] = 1'b0;
        end else if (pend[i] && edge_n == resp_e[i]) begin
          pend[i] = 1'b0;
          last_resp[i] = edge_n;
          off = p_adr[i] - BASE;
          ok  = (p_adr[i] >= BASE) && (p_adr[i] < BASE + 64'(DEPTH) * 8);
`ifdef WB_RAM_ALIGN_CHECK_EN
          if (p_adr[i][2:0] != 3'd0) ok = 1'b0;
`endif
          idx = int'(off / 8);
          if (ok) begin
            m_ack[i] = 1'b1;
            if (p_we[i]) begin
              for (int b = 0; b < 8; b++)
                if (p_sel[i][b]) m_mem[i][idx][8*b +: 8] = p_dat[i][8*b +: 8];
            end else begin
              m_dat[i] = m_mem[i][idx];
            end
          end else begin
            m_err[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int i, input logic w, input logic [7:0] s, input logic [63:0] a,
                      input logic [63:0] d, output int lat, output logic ga, output logic ge);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; adr[i] = a; wdat[i] = d;
    @(posedge clk); @(negedge clk);
    lat = 0;
    while (!ack_o[i] && !err_o[i] && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    ga = ack_o[i]; ge = err_o[i];
    cyc[i] = 1'b0; stb[i] = 1'b0;
    if (lat >= 20) chk("xfer_timeout", 64'(lat), 64'd0);
    @(negedge clk);
  endtask

  int   lat;
  logic ga, ge;
  int   a0, e0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = '0; adr[i] = '0; wdat[i] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          n_cmp++;
          if (ack_o[i] !== m_ack[i] || err_o[i] !== m_err[i] || dat_o[i] !== m_dat[i]) begin
            n_fail++;
            $display("FAIL model_cmp inst%0d: got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                     i, ack_o[i], err_o[i], dat_o[i], m_ack[i], m_err[i], m_dat[i]);
          end
          if (ack_o[i] === 1'b1) ack_cnt[i]++;
          if (err_o[i] === 1'b1) err_cnt[i]++;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", 64'(ack_o[i]), 64'd0);
      chk("rst_err", 64'(err_o[i]), 64'd0);
      chk("rst_dat", dat_o[i], 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full write then read, one wait state
    xfer(1, 1'b1, 8'hff, BASE + 8, 64'h1122334455667788, lat, ga, ge);
    chk("t1_wr_lat", 64'(lat), 64'd1);
    chk("t1_wr_ack", 64'(ga), 64'd1);
    xfer(1, 1'b0, 8'h00, BASE + 8, 64'h0, lat, ga, ge);
    chk("t1_rd_lat", 64'(lat), 64'd1);
    chk("t1_rd_dat", dat_o[1], 64'h1122334455667788);

    // Partial byte-lane write
    xfer(1, 1'b1, 8'h0f, BASE + 8, 64'hAAAAAAAA_BBBBBBBB, lat, ga, ge);
    xfer(1, 1'b0, 8'h00, BASE + 8, 64'h0, lat, ga, ge);
    chk("t2_rd_dat", dat_o[1], 64'h11223344_BBBBBBBB);

    // Misses: one past the top, and just below the base
    xfer(1, 1'b0, 8'h00, BASE + 64'(DEPTH) * 8, 64'h0, lat, ga, ge);
    chk("t3_err", 64'(ge), 64'd1);
    chk("t3_noack", 64'(ga), 64'd0);
    chk("t3_err_1cyc", 64'(err_o[1]), 64'd0);
    chk("t3_dat_held", dat_o[1], 64'h11223344_BBBBBBBB);
    xfer(1, 1'b1, 8'hff, BASE + 64'h78, 64'h0F0F0F0F_0F0F0F0F, lat, ga, ge);
    xfer(1, 1'b1, 8'hff, BASE - 8, 64'hFFFFFFFF_FFFFFFFF, lat, ga, ge);
    chk("t3_wr_err", 64'(ge), 64'd1);
    xfer(1, 1'b0, 8'h00, BASE + 64'h78, 64'h0, lat, ga, ge);
    chk("t3_ram_kept", dat_o[1], 64'h0F0F0F0F_0F0F0F0F);

    // Zero wait states: stb held for 6 cycles gives 3 acks on alternate cycles
    xfer(0, 1'b1, 8'hff, BASE + 64'h00, 64'hDEADBEEF_00000001, lat, ga, ge);
    chk("t4_w0_lat", 64'(lat), 64'd0);
    xfer(0, 1'b1, 8'hff, BASE + 64'h10, 64'hDEADBEEF_00000002, lat, ga, ge);
    xfer(0, 1'b1, 8'hff, BASE + 64'h20, 64'hDEADBEEF_00000003, lat, ga, ge);
    xfer(0, 1'b1, 8'h00, BASE + 64'h30, 64'hFFFFFFFF_FFFFFFFF, lat, ga, ge);
    chk("t4_sel0_ack", 64'(ga), 64'd1);
    a0 = ack_cnt[0];
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      adr[0] = BASE + 64'(16 * (j / 2));
      @(posedge clk); @(negedge clk);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    chk("t4_ack_count", 64'(ack_cnt[0] - a0), 64'd3);
    chk("t4_last_dat", dat_o[0], 64'hDEADBEEF_00000003);

    // Abort by dropping cyc while waiting, three wait states
    xfer(2, 1'b1, 8'hff, BASE + 64'h30, 64'h55555555_66666666, lat, ga, ge);
    chk("t5_w3_lat", 64'(lat), 64'd3);
    a0 = ack_cnt[2]; e0 = err_cnt[2];
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 8'hff; adr[2] = BASE + 64'h30;
    wdat[2] = 64'h99999999_99999999;
    @(posedge clk); @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_abort_noack", 64'(ack_cnt[2] - a0), 64'd0);
    chk("t5_abort_noerr", 64'(err_cnt[2] - e0), 64'd0);
    xfer(2, 1'b0, 8'h00, BASE + 64'h30, 64'h0, lat, ga, ge);
    chk("t5_abort_kept", dat_o[2], 64'h55555555_66666666);

    // Reset in the middle of a pending write
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 8'hff; adr[2] = BASE + 64'h30;
    wdat[2] = 64'h77777777_77777777;
    @(posedge clk); @(negedge clk); @(posedge clk);
    #2 rst = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
    #1 chk("t5_rst_wait_ack", 64'(ack_o[2]), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    xfer(2, 1'b0, 8'h00, BASE + 64'h30, 64'h0, lat, ga, ge);
    chk("t5_rst_dropped_wr", dat_o[2], 64'h55555555_66666666);

    // Reset while the ack pulse is high clears it at once
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = BASE + 8;
    @(posedge clk); @(posedge clk);
    #2 chk("t5_ack_before_rst", 64'(ack_o[1]), 64'd1);
    rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    #1 chk("t5_ack_cleared", 64'(ack_o[1]), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Misaligned read inside the window
    xfer(0, 1'b0, 8'h00, BASE + 3, 64'h0, lat, ga, ge);
`ifdef WB_RAM_ALIGN_CHECK_EN
    chk("t6_misalign_err", 64'(ge), 64'd1);
    chk("t6_misalign_dat", dat_o[0], 64'd0);
`else
    chk("t6_misalign_ack", 64'(ga), 64'd1);
    chk("t6_misalign_dat", dat_o[0], 64'hDEADBEEF_00000001);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
